axi4_data_width_converter_32to64: RTL

AXI4 upsizer bridging a 32-bit AXI4 manager (`in_*`) to a 64-bit AXI4 subordinate (`out_*`); the companion of the 64-to-32 downsizer, used where a 32-bit core master reaches 64-bit memory or crossbar ports. Bursts pass through unchanged in length and size as narrow transfers on the 64-bit bus; the block tracks each beat's address to steer read data from, and write data/strobes into, the correct 32-bit lane. One outstanding transaction per direction; the read and write paths are fully independent.

---
 rtl/axi4_data_width_converter_32to64.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_data_width_converter_32to64.sv
// AXI4 upsizer: 32-bit manager (in_*) to 64-bit subordinate (out_*), one outstanding burst per direction.
// Latency: AR/AW register one cycle; R, W and B are combinational pass-through (one beat/cycle).
// Backpressure: in_arready/in_awready only in IDLE; in_wready held low until AW is accepted downstream.
//
// Ports:
//   clock, reset               sole clock, synchronous active-high reset
//   in_ar*/in_r*               32-bit side read address / read data
//   in_aw*/in_w*/in_b*         32-bit side write address / write data / write response
//   out_ar*/out_r*             64-bit side read address / read data (rdata 64)
//   out_aw*/out_w*/out_b*      64-bit side write channels (wdata 64, wstrb 8)
module axi4_data_width_converter_32to64 (
  input  logic        clock,
  input  logic        reset,
  // 32-bit side read address
  input  logic        in_arvalid,
  output logic        in_arready,
  input  logic [3:0]  in_arid,
  input  logic [31:0] in_araddr,
  input  logic [7:0]  in_arlen,
  input  logic [2:0]  in_arsize,
  input  logic [1:0]  in_arburst,
  // 32-bit side read data
  output logic        in_rvalid,
  input  logic        in_rready,
  output logic [3:0]  in_rid,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic        in_rlast,
  // 32-bit side write address
  input  logic        in_awvalid,
  output logic        in_awready,
  input  logic [3:0]  in_awid,
  input  logic [31:0] in_awaddr,
  input  logic [7:0]  in_awlen,
  input  logic [2:0]  in_awsize,
  input  logic [1:0]  in_awburst,
  // 32-bit side write data
  input  logic        in_wvalid,
  output logic        in_wready,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  input  logic        in_wlast,
  // 32-bit side write response
  output logic        in_bvalid,
  input  logic        in_bready,
  output logic [3:0]  in_bid,
  output logic [1:0]  in_bresp,
  // 64-bit side read address
  output logic        out_arvalid,
  input  logic        out_arready,
  output logic [3:0]  out_arid,
  output logic [31:0] out_araddr,
  output logic [7:0]  out_arlen,
  output logic [2:0]  out_arsize,
  output logic [1:0]  out_arburst,
  // 64-bit side read data
  input  logic        out_rvalid,
  output logic        out_rready,
  input  logic [3:0]  out_rid,
  input  logic [63:0] out_rdata,
  input  logic [1:0]  out_rresp,
  input  logic        out_rlast,
  // 64-bit side write address
  output logic        out_awvalid,
  input  logic        out_awready,
  output logic [3:0]  out_awid,
  output logic [31:0] out_awaddr,
  output logic [7:0]  out_awlen,
  output logic [2:0]  out_awsize,
  output logic [1:0]  out_awburst,
  // 64-bit side write data
  output logic        out_wvalid,
  input  logic        out_wready,
  output logic [63:0] out_wdata,
  output logic [7:0]  out_wstrb,
  output logic        out_wlast,
  // 64-bit side write response
  input  logic        out_bvalid,
  output logic        out_bready,
  input  logic [3:0]  out_bid,
  input  logic [1:0]  out_bresp
);

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_t;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  // Address of the following beat. Size is clamped to the 32-bit upstream
  // width; the reserved burst encoding behaves as INCR.
  function automatic logic [31:0] next_beat_addr(
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [2:0]  s;
    logic [31:0] inc;
    logic [31:0] mask;
    logic [31:0] nxt;
    s    = (size > 3'd2) ? 3'd2 : size;
    inc  = 32'd1 << s;
    mask = (({24'd0, len} + 32'd1) << s) - 32'd1;
    case (burst)
      2'b00:   nxt = addr;
      2'b10:   nxt = (addr & ~mask) | ((addr + inc) & mask);
      default: nxt = addr + inc;
    endcase
    return nxt;
  endfunction

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [1:0]  r_state_q, r_state_d;
  ax_t         ar_q, ar_d;
  logic [31:0] raddr_q, raddr_d;

  logic ar_hs, ar_out_hs, r_hs;

  assign ar_hs     = (r_state_q == R_IDLE) && in_arvalid;
  assign ar_out_hs = (r_state_q == R_ADDR) && out_arready;
  assign r_hs      = (r_state_q == R_DATA) && out_rvalid && in_rready;

  always_comb begin
    r_state_d = r_state_q;
    ar_d      = ar_q;
    raddr_d   = raddr_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          ar_d      = '{id: in_arid, addr: in_araddr, len: in_arlen,
                        size: in_arsize, burst: in_arburst};
          raddr_d   = in_araddr;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ar_out_hs) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (r_hs) begin
          raddr_d = next_beat_addr(raddr_q, ar_q.len, ar_q.size, ar_q.burst);
          if (out_rlast) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      ar_q      <= '0;
      raddr_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_q      <= ar_d;
      raddr_q   <= raddr_d;
    end
  end

  assign in_arready  = (r_state_q == R_IDLE);
  assign out_arvalid = (r_state_q == R_ADDR);
  assign out_arid    = ar_q.id;
  assign out_araddr  = ar_q.addr;
  assign out_arlen   = ar_q.len;
  assign out_arsize  = ar_q.size;
  assign out_arburst = ar_q.burst;

  assign in_rvalid  = (r_state_q == R_DATA) && out_rvalid;
  assign out_rready = (r_state_q == R_DATA) && in_rready;
  assign in_rid     = out_rid;
  assign in_rresp   = out_rresp;
  assign in_rlast   = out_rlast;
  // Address bit 2 selects which 32-bit half of the 64-bit beat is live.
  assign in_rdata   = raddr_q[2] ? out_rdata[63:32] : out_rdata[31:0];

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------
  logic [1:0]  w_state_q, w_state_d;
  ax_t         aw_q, aw_d;
  logic [31:0] waddr_q, waddr_d;

  logic aw_hs, aw_out_hs, w_hs, b_hs;

  assign aw_hs     = (w_state_q == W_IDLE) && in_awvalid;
  assign aw_out_hs = (w_state_q == W_ADDR) && out_awready;
  assign w_hs      = (w_state_q == W_DATA) && in_wvalid && out_wready;
  assign b_hs      = (w_state_q == W_RESP) && out_bvalid && in_bready;

  always_comb begin
    w_state_d = w_state_q;
    aw_d      = aw_q;
    waddr_d   = waddr_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_d      = '{id: in_awid, addr: in_awaddr, len: in_awlen,
                        size: in_awsize, burst: in_awburst};
          waddr_d   = in_awaddr;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (aw_out_hs) w_state_d = W_DATA;
      end
      W_DATA: begin
        if (w_hs) begin
          waddr_d = next_beat_addr(waddr_q, aw_q.len, aw_q.size, aw_q.burst);
          if (in_wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      aw_q      <= '0;
      waddr_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_q      <= aw_d;
      waddr_q   <= waddr_d;
    end
  end

  assign in_awready  = (w_state_q == W_IDLE);
  assign out_awvalid = (w_state_q == W_ADDR);
  assign out_awid    = aw_q.id;
  assign out_awaddr  = aw_q.addr;
  assign out_awlen   = aw_q.len;
  assign out_awsize  = aw_q.size;
  assign out_awburst = aw_q.burst;

  // W beats are only forwarded once the subordinate owns the address.
  assign out_wvalid = (w_state_q == W_DATA) && in_wvalid;
  assign in_wready  = (w_state_q == W_DATA) && out_wready;
  assign out_wlast  = in_wlast;
  // Data is replicated to both halves; the strobe picks the live lane.
  assign out_wdata  = {in_wdata, in_wdata};
  assign out_wstrb  = waddr_q[2] ? {in_wstrb, 4'h0} : {4'h0, in_wstrb};

  assign in_bvalid  = (w_state_q == W_RESP) && out_bvalid;
  assign out_bready = (w_state_q == W_RESP) && in_bready;
  assign in_bid     = out_bid;
  assign in_bresp   = out_bresp;

endmodule
